defuzz_wavg: RTL and testbench

- Defuzzification stage directly downstream of the 3x3 rule-weight grid.
- Accepts the nine min()-derived rule weights w00..w22 in one transfer.
- Computes the singleton weighted average y = sum(w_i*C_i) / sum(w_i) with a serial multiply-accumulate (MAC) followed by a bit-serial restoring divider.
- Returns a signed 16-bit crisp output through a valid/ready handshake.

---
 rtl/fuzzy_pkg.sv | 18 +
 rtl/seq_udiv.sv | 80 ++++++++
 rtl/defuzz_wavg.sv | 171 +++++++++++++++++
 tb/tb_defuzz_wavg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared widths, types and FSM encoding for the rule-grid defuzzification stage.
package fuzzy_pkg;
    localparam int unsigned MU_W      = 16;
    localparam int unsigned ACC_W     = 37;
    localparam int unsigned WS_W      = 20;
    localparam int unsigned N_RULES   = 9;
    localparam int unsigned DIV_STEPS = 37;

    typedef logic [MU_W-1:0]   mu_t;
    typedef logic signed [15:0] crisp_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DIV,
        DONE
    } defuzz_state_t;
endpackage

// File: rtl/seq_udiv.sv
// Bit-serial unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_udiv #(
    parameter int unsigned DVD_W = 37,
    parameter int unsigned DVS_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DVS_W-1:0] rem_src;
    logic [DVS_W-1:0] dvs_src;
    logic [DVD_W-1:0] dvd_src;
    logic [DVS_W:0]   shifted;
    logic             qbit;

    // The start cycle already performs the first step on the incoming operands,
    // so the full quotient is ready DVD_W edges after start.
    always_comb begin
        rem_src = start ? '0 : rem_q;
        dvd_src = start ? dividend : dvd_q;
        dvs_src = start ? divisor : dvs_q;
        shifted = {rem_src, dvd_src[DVD_W-1]};
        qbit    = (shifted >= {1'b0, dvs_src});

        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            rem_d  = qbit ? DVS_W'(shifted - {1'b0, dvs_src}) : shifted[DVS_W-1:0];
            dvd_d  = {dvd_src[DVD_W-2:0], qbit};
            dvs_d  = dvs_src;
            cnt_d  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            busy_d = 1'b1;
            if (cnt_d == CNT_W'(DVD_W)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dvd_q;
endmodule

// File: rtl/defuzz_wavg.sv
// Singleton weighted-average defuzzifier: serial MAC over nine rule weights, then serial divide.
module defuzz_wavg #(
    parameter logic signed [15:0] RULE_C [9] = '{
        -16'sd24576, -16'sd16384, -16'sd8192,
        -16'sd8192,   16'sd0,      16'sd8192,
         16'sd8192,   16'sd16384,  16'sd24576
    },
    parameter int unsigned ACC_W = 37,
    parameter int unsigned WS_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        w00,
    input  logic [15:0]        w01,
    input  logic [15:0]        w02,
    input  logic [15:0]        w10,
    input  logic [15:0]        w11,
    input  logic [15:0]        w12,
    input  logic [15:0]        w20,
    input  logic [15:0]        w21,
    input  logic [15:0]        w22,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] y,
    output logic               zero_w
);
    import fuzzy_pkg::*;

    localparam int unsigned PROD_W = MU_W + 17;
    localparam logic [ACC_W-1:0] POS_LIM = ACC_W'(32767);
    localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(32768);

    defuzz_state_t state_q, state_d;
    mu_t                     w_q [N_RULES];
    mu_t                     w_d [N_RULES];
    logic signed [ACC_W-1:0] num_q, num_d;
    logic [WS_W-1:0]         wsum_q, wsum_d;
    logic [3:0]              idx_q, idx_d;
    crisp_t                  y_q, y_d;
    logic                    zero_w_q, zero_w_d;
    logic                    neg_q, neg_d;

    mu_t                      w_cur;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]         num_mag;
    logic                     div_start, div_busy, div_done;
    logic [ACC_W-1:0]         quot;
    crisp_t                   y_sat;

    assign w_cur    = w_q[idx_q];
    assign prod     = $signed({1'b0, w_cur}) * RULE_C[idx_q];
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign num_mag  = num_d[ACC_W-1] ? -num_d : num_d;

    always_comb begin
        if (neg_q) begin
            y_sat = (quot > NEG_LIM) ? 16'sh8000 : crisp_t'(16'd0 - quot[15:0]);
        end else begin
            y_sat = (quot > POS_LIM) ? 16'sh7fff : crisp_t'(quot[15:0]);
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        num_d     = num_q;
        wsum_d    = wsum_q;
        idx_d     = idx_q;
        y_d       = y_q;
        zero_w_d  = zero_w_q;
        neg_d     = neg_q;
        div_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d[0]  = w00;
                    w_d[1]  = w01;
                    w_d[2]  = w02;
                    w_d[3]  = w10;
                    w_d[4]  = w11;
                    w_d[5]  = w12;
                    w_d[6]  = w20;
                    w_d[7]  = w21;
                    w_d[8]  = w22;
                    num_d   = '0;
                    wsum_d  = '0;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                num_d  = num_q + prod_ext;
                wsum_d = wsum_q + {{(WS_W-MU_W){1'b0}}, w_cur};
                idx_d  = idx_q + 4'd1;
                // Divider is launched from the post-add totals so DIV needs no extra load cycle.
                if (idx_q == 4'(N_RULES - 1)) begin
                    idx_d = '0;
                    if (wsum_d == '0) begin
                        y_d      = '0;
                        zero_w_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        neg_d     = num_d[ACC_W-1];
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done && !div_busy) begin
                    y_d      = y_sat;
                    zero_w_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int unsigned i = 0; i < N_RULES; i++) begin
                w_q[i] <= '0;
            end
            num_q    <= '0;
            wsum_q   <= '0;
            idx_q    <= '0;
            y_q      <= '0;
            zero_w_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            num_q    <= num_d;
            wsum_q   <= wsum_d;
            idx_q    <= idx_d;
            y_q      <= y_d;
            zero_w_q <= zero_w_d;
            neg_q    <= neg_d;
        end
    end

    seq_udiv #(
        .DVD_W(ACC_W),
        .DVS_W(WS_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (num_mag),
        .divisor  (wsum_d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign zero_w    = zero_w_q;
endmodule

// File: tb/tb_defuzz_wavg.sv
// Scoreboard bench for defuzz_wavg: directed weight vectors with hand-computed results.
module tb_defuzz_wavg;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               zero_w;
    logic signed [15:0] y;
    logic [15:0]        wr [9];

    typedef struct {
        int y;
        int zw;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    bit   seen = 1'b0;
    bit   skip = 1'b0;

    defuzz_wavg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w00       (wr[0]),
        .w01       (wr[1]),
        .w02       (wr[2]),
        .w10       (wr[3]),
        .w11       (wr[4]),
        .w12       (wr[5]),
        .w20       (wr[6]),
        .w21       (wr[7]),
        .w22       (wr[8]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero_w    (zero_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: pops one expectation per result, checks latency once and value every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
            skip = 1'b0;
        end else begin
            if (in_valid && in_ready) accept_cyc = cyc + 1;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        skip = 1'b1;
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got y=%0d zero_w=%0d, expected no result", y, zero_w);
                    end else begin
                        skip = 1'b0;
                        cur = exp_q.pop_front();
                        chk("latency", cyc - accept_cyc, cur.lat);
                    end
                end
                if (!skip) begin
                    chk("y", int'(y), cur.y);
                    chk("zero_w", int'(zero_w), cur.zw);
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [143:0] wv, input int ey, input int ezw, input int elat, input bit push);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        for (int i = 0; i < 9; i++) wr[i] = wv[(8-i)*16 +: 16];
        if (push) exp_q.push_back('{y: ey, zw: ezw, lat: elat});
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) wr[i] = 16'hA5A5;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) wr[i] = '0;
        #22 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_zero_w", int'(zero_w), 0);

        send({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 46, 1);
        send({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000}, 24576, 0, 46, 1);
        send({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000}, 12288, 0, 46, 1);
        send({16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, -19114, 0, 46, 1);
        send({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 1, 9, 1);
        send({16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h0000}, 2048, 0, 46, 1);
        send({16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, -17554, 0, 46, 1);
        send({16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, -24576, 0, 46, 1);
        send({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 0, 46, 1);
        wait_idle();

        // Backpressure: result must hold while out_ready is low; a stray in_valid is dropped.
        out_ready = 1'b0;
        send({16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0000}, 4096, 0, 46, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!out_valid) chk("bp_valid_timeout", 0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                wr[8] = 16'h1000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (60) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of DIV aborts the result.
        send({16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_zero_w", int'(zero_w), 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        send({16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000}, 0, 0, 46, 1);
        send({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000}, 24576, 0, 46, 1);
        wait_idle();
        repeat (60) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end
endmodule
